// File: rtl/ace_pkg.sv
// Shared ACE snoop types: AC snoop opcodes, decoder snoop info, CR response bits
// and the accumulator used while merging per-port snoop responses.
package ace_pkg;

  typedef enum logic [3:0] {
    ACSNOOP_READ_ONCE          = 4'b0000,
    ACSNOOP_READ_SHARED        = 4'b0001,
    ACSNOOP_READ_CLEAN         = 4'b0010,
    ACSNOOP_READ_NOT_SHARED_DIRTY = 4'b0011,
    ACSNOOP_READ_UNIQUE        = 4'b0111,
    ACSNOOP_CLEAN_SHARED       = 4'b1000,
    ACSNOOP_CLEAN_INVALID      = 4'b1001,
    ACSNOOP_MAKE_INVALID       = 4'b1101
  } acsnoop_t;

  typedef struct packed {
    acsnoop_t snoop_trs;
    logic     accepts_dirty;
  } snoop_info_t;

  // Field order places WasUnique at bit 4 and DataTransfer at bit 0.
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic data_avail;
    logic pass_dirty;
    logic is_shared;
    logic was_unique;
    logic error;
  } merge_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_RESP
  } disp_state_e;

  localparam int unsigned CrRespWidth = 5;

  function automatic merge_flags_t merge_flags_or(input merge_flags_t acc, input crresp_t r);
    merge_flags_t res;
    res            = acc;
    res.pass_dirty = acc.pass_dirty | r.pass_dirty;
    res.is_shared  = acc.is_shared  | r.is_shared;
    res.was_unique = acc.was_unique | r.was_unique;
    res.error      = acc.error      | r.error;
    return res;
  endfunction

endpackage

// File: rtl/ace_snoop_resp_merge.sv
// Folds one port's CR handshake into the running snoop result; chaining these in
// ascending port order keeps the lowest-index DataTransfer port.
module ace_snoop_resp_merge
  import ace_pkg::*;
#(
  parameter int unsigned IdxWidth = 2
) (
  input  logic                hs_i,
  input  crresp_t             resp_i,
  input  logic [IdxWidth-1:0] idx_i,
  input  merge_flags_t        flags_i,
  input  logic [IdxWidth-1:0] port_i,
  output merge_flags_t        flags_o,
  output logic [IdxWidth-1:0] port_o
);

  always_comb begin
    flags_o = flags_i;
    port_o  = port_i;
    if (hs_i) begin
      flags_o = merge_flags_or(flags_i, resp_i);
      if (resp_i.data_transfer && (!flags_i.data_avail || (idx_i < port_i))) begin
        flags_o.data_avail = 1'b1;
        port_o             = idx_i;
      end
    end
  end

endmodule

// File: rtl/ace_snoop_dispatcher.sv
// Broadcasts one AC snoop to every master except the initiator, collects the CR
// responses and presents a single merged snoop result downstream.
module ace_snoop_dispatcher
  import ace_pkg::*;
#(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [AddrWidth-1:0]            req_addr_i,
  input  logic [2:0]                      req_prot_i,
  input  snoop_info_t                     req_snoop_info_i,
  input  logic [IdxWidth-1:0]             req_initiator_i,
  output logic [NumPorts-1:0]             ac_valid_o,
  input  logic [NumPorts-1:0]             ac_ready_i,
  output logic [AddrWidth-1:0]            ac_addr_o,
  output acsnoop_t                        ac_snoop_o,
  output logic [2:0]                      ac_prot_o,
  input  logic [NumPorts-1:0]             cr_valid_i,
  output logic [NumPorts-1:0]             cr_ready_o,
  input  logic [NumPorts*CrRespWidth-1:0] cr_resp_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic                            rsp_data_avail_o,
  output logic [IdxWidth-1:0]             rsp_data_port_o,
  output logic                            rsp_pass_dirty_o,
  output logic                            rsp_is_shared_o,
  output logic                            rsp_was_unique_o,
  output logic                            rsp_error_o,
  output logic                            rsp_writeback_o
);

  disp_state_e          state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [2:0]           prot_q, prot_d;
  snoop_info_t          info_q, info_d;
  logic [NumPorts-1:0]  mask_q, mask_d;
  logic [NumPorts-1:0]  ac_done_q, ac_done_d;
  logic [NumPorts-1:0]  cr_done_q, cr_done_d;
  merge_flags_t         flags_q, flags_d;
  logic [IdxWidth-1:0]  port_q, port_d;

  logic                 in_snoop, in_resp;
  logic [NumPorts-1:0]  req_mask;
  logic [NumPorts-1:0]  ac_hs, cr_hs;
  merge_flags_t         flags_chain [NumPorts+1];
  logic [IdxWidth-1:0]  port_chain  [NumPorts+1];

  assign in_snoop = (state_q == ST_SNOOP);
  assign in_resp  = (state_q == ST_RESP);

  assign flags_chain[0] = flags_q;
  assign port_chain[0]  = port_q;

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    assign req_mask[gi] = (req_initiator_i != IdxWidth'(gi));

    ace_snoop_resp_merge #(
      .IdxWidth (IdxWidth)
    ) u_merge (
      .hs_i    (cr_hs[gi]),
      .resp_i  (crresp_t'(cr_resp_i[gi*CrRespWidth +: CrRespWidth])),
      .idx_i   (IdxWidth'(gi)),
      .flags_i (flags_chain[gi]),
      .port_i  (port_chain[gi]),
      .flags_o (flags_chain[gi+1]),
      .port_o  (port_chain[gi+1])
    );
  end

  // A port's CR is only accepted once its AC handshake has been registered.
  assign ac_valid_o = in_snoop ? (mask_q & ~ac_done_q) : '0;
  assign cr_ready_o = in_snoop ? (ac_done_q & ~cr_done_q) : '0;
  assign ac_hs      = ac_valid_o & ac_ready_i;
  assign cr_hs      = cr_ready_o & cr_valid_i;

  assign ac_addr_o  = addr_q;
  assign ac_snoop_o = info_q.snoop_trs;
  assign ac_prot_o  = prot_q;

  assign req_ready_o      = rdy_q;
  assign rsp_valid_o      = in_resp;
  assign rsp_data_avail_o = in_resp & flags_q.data_avail;
  assign rsp_data_port_o  = in_resp ? port_q : '0;
  assign rsp_pass_dirty_o = in_resp & flags_q.pass_dirty;
  assign rsp_is_shared_o  = in_resp & flags_q.is_shared;
  assign rsp_was_unique_o = in_resp & flags_q.was_unique;
  assign rsp_error_o      = in_resp & flags_q.error;
  assign rsp_writeback_o  = in_resp & flags_q.pass_dirty & ~info_q.accepts_dirty;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    info_d    = info_q;
    mask_d    = mask_q;
    ac_done_d = ac_done_q;
    cr_done_d = cr_done_q;
    flags_d   = flags_q;
    port_d    = port_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && rdy_q) begin
          addr_d    = req_addr_i;
          prot_d    = req_prot_i;
          info_d    = req_snoop_info_i;
          mask_d    = req_mask;
          ac_done_d = '0;
          cr_done_d = '0;
          flags_d   = '0;
          port_d    = '0;
          state_d   = (req_mask == '0) ? ST_RESP : ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        ac_done_d = ac_done_q | ac_hs;
        cr_done_d = cr_done_q | cr_hs;
        flags_d   = flags_chain[NumPorts];
        port_d    = port_chain[NumPorts];
        if (cr_done_d == mask_q) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      prot_q    <= '0;
      info_q    <= '0;
      mask_q    <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      flags_q   <= '0;
      port_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      info_q    <= info_d;
      mask_q    <= mask_d;
      ac_done_q <= ac_done_d;
      cr_done_q <= cr_done_d;
      flags_q   <= flags_d;
      port_q    <= port_d;
    end
  end

endmodule
